// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter fed by a small word FIFO; optional parity, 1 or 2 stops.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          parity_en,
    input  logic                          odd,
    input  logic                          two_stop,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_CLKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BCW      = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int NBW      = $clog2(DATA_BITS);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CLKS - 1);
    localparam logic [NBW-1:0] DATA_LAST = NBW'(DATA_BITS - 1);
    localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BCW-1:0]         baud_q, baud_d;
    logic [NBW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   two_stop_q, two_stop_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];

    logic push;
    logic pop;
    logic baud_end;

    assign din_ready  = (count_q != DEPTH_C);
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign fifo_count = count_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        push       = din_valid && din_ready;
        pop        = 1'b0;
        baud_end   = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // bit_q counts completed stop bits when two are requested
                    if (!two_stop_q || bit_q[0]) begin
                        done_d = 1'b1;
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame options are captured here so later input changes cannot disturb the frame
        if (pop) begin
            shift_d    = mem_q[rd_ptr_q];
            par_en_d   = parity_en;
            par_bit_d  = (^mem_q[rd_ptr_q]) ^ odd;
            two_stop_d = two_stop;
            tx_d       = 1'b0;
            baud_d     = '0;
            bit_d      = '0;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            state_d    = START;
        end

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Scoreboard bench for uart_tx_fifo (BIT_CLKS=16, 8 data bits, depth 4).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int BIT_CLKS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       pen;
        logic       odd;
        logic       ts;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       parity_en = 1'b0;
    logic       odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       tx_out;
    logic       busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t exp_q[$];
    vec_t cur;
    logic in_frame = 1'b0;
    int   cyc      = 0;
    int   flen     = 0;
    int   b2b      = 0;

    uart_tx_fifo #(
        .CLK_FREQUENCY(16),
        .BAUD_RATE    (1),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .parity_en (parity_en),
        .odd       (odd),
        .two_stop  (two_stop),
        .tx_out    (tx_out),
        .busy      (busy),
        .tx_done   (tx_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
        if (k == 0)                 return 1'b0;
        if (k <= 8)                 return v.data[k-1];
        if (v.pen && k == 9)        return v.par;
        return 1'b1;
    endfunction

    task start_frame();
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            cur = '0;
        end else begin
            cur = exp_q.pop_front();
        end
        flen     = BIT_CLKS * (10 + int'(cur.pen) + int'(cur.ts));
        cyc      = 0;
        in_frame = 1'b1;
        check("start_low", {31'd0, tx_out}, 32'd0);
    endtask

    // Monitor: frame-aligned checks of every bit, busy and tx_done
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else if (in_frame) begin
            cyc++;
            if (cyc < flen) begin
                if (cyc % BIT_CLKS == BIT_CLKS / 2)
                    check($sformatf("bit%0d_of_%0h", cyc / BIT_CLKS, cur.data),
                          {31'd0, tx_out}, {31'd0, exp_bit(cur, cyc / BIT_CLKS)});
                check("busy_mid_frame", {30'd0, busy, tx_done}, 32'b10);
            end else begin
                check($sformatf("tx_done_end_%0h", cur.data), {31'd0, tx_done}, 32'd1);
                in_frame = 1'b0;
                if (busy) begin
                    b2b++;
                    start_frame();
                end
            end
        end else if (busy) begin
            start_frame();
        end
    end

    task automatic push_word(input vec_t v);
        int n = 0;
        @(negedge clk);
        din       = v.data;
        parity_en = v.pen;
        odd       = v.odd;
        two_stop  = v.ts;
        din_valid = 1'b1;
        while (!din_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            check("push_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            exp_q.push_back(v);
        end
        #1 din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_count != 0 || in_frame) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'd0, (n >= 4000)}, 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    logic [7:0] words   [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    initial begin
        logic acc;
        int   b0;
        int   n;
        logic bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_din_ready", {31'd0, din_ready}, 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_frame", {31'd0, busy}, 32'd0);

        // 0x55, no parity, one stop: 160-cycle frame
        push_word('{data: 8'h55, pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        wait_idle("f55");

        // 0x07 with odd parity (parity 0) then even parity (parity 1)
        push_word('{data: 8'h07, pen: 1'b1, odd: 1'b1, ts: 1'b0, par: 1'b0});
        wait_idle("f07_odd");
        push_word('{data: 8'h07, pen: 1'b1, odd: 1'b0, ts: 1'b0, par: 1'b1});
        wait_idle("f07_even");

        // Burst of six pushes: the first word is popped on the second edge,
        // so five are taken before the FIFO fills.
        parity_en = 1'b0; odd = 1'b0; two_stop = 1'b0;
        b0 = b2b;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din       = words[i];
            din_valid = 1'b1;
            check($sformatf("burst_ready_%0d", i), {31'd0, din_ready}, {31'd0, exp_rdy[i]});
            acc = din_ready;
            @(posedge clk);
            if (acc) exp_q.push_back('{data: words[i], pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
            #1;
            check($sformatf("burst_count_%0d", i), {29'd0, fifo_count}, {29'd0, exp_cnt[i]});
        end
        n = 0;
        while (!din_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("burst_ready_rise", {31'd0, din_ready}, 32'd1);
        check("burst_count_after_pop", {29'd0, fifo_count}, 32'd3);
        @(posedge clk);
        if (din_ready) exp_q.push_back('{data: words[5], pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        #1 din_valid = 1'b0;
        check("burst_count_refill", {29'd0, fifo_count}, 32'd4);
        wait_idle("burst");
        check("burst_back_to_back", b2b - b0, 32'd5);

        // Two stops + parity on 0xFF (192 cycles); option changes mid-frame are ignored
        push_word('{data: 8'hFF, pen: 1'b1, odd: 1'b0, ts: 1'b1, par: 1'b0});
        repeat (60) @(negedge clk);
        two_stop = 1'b0; odd = 1'b1;
        repeat (60) @(negedge clk);
        parity_en = 1'b0;
        wait_idle("fFF_2stop");
        push_word('{data: 8'h3C, pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        repeat (40) @(negedge clk);
        two_stop = 1'b1; parity_en = 1'b1;
        wait_idle("f3C_toggle");

        // Reset at about cycle 50 of a frame with two words queued
        push_word('{data: 8'h11, pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        push_word('{data: 8'h22, pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        push_word('{data: 8'h33, pen: 1'b0, odd: 1'b0, ts: 1'b0, par: 1'b0});
        check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
        repeat (45) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (busy || !tx_out || fifo_count != 0) bad = 1'b1;
        end
        check("no_frame_after_rst", {31'd0, bad}, 32'd0);
        push_word('{data: 8'hA5, pen: 1'b1, odd: 1'b1, ts: 1'b1, par: 1'b1});
        wait_idle("fA5_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
